// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: holds the PC, fetches words over a request/valid
// handshake and issues them to decode. Optional macro FETCH_BRANCH_STATS_EN enables TAKEN_COUNT.
module instr_fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int OPC_W   = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [PC_W-1:0]    START_ADDR,
    output logic               IMEM_REQ,
    output logic [PC_W-1:0]    IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    input  logic               IMEM_VALID,
    output logic [OPC_W-1:0]   OPCODE,
    output logic [INSTR_W-1:0] INSTR,
    output logic               INSTR_VALID,
    input  logic               ACCEPT,
    input  logic               BRANCH,
    input  logic               TAKEN,
    input  logic [PC_W-1:0]    BRANCH_TARGET,
    input  logic               HALT,
    output logic [PC_W-1:0]    PC,
    output logic               RUNNING,
    output logic [15:0]        INSTR_COUNT,
    output logic [15:0]        TAKEN_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PC_W-1:0]      pc_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [15:0]          instr_cnt;
    logic                 start_ok;
    logic                 retire;
    logic                 take;

    always_comb begin
        start_ok = START && (state == S_IDLE || state == S_HALTED);
        retire   = (state == S_ISSUE) && ACCEPT;
        take     = retire && !HALT && BRANCH && TAKEN;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALTED: if (START) state_nxt = S_FETCH;
            S_FETCH:          if (IMEM_VALID) state_nxt = S_ISSUE;
            S_ISSUE:          if (ACCEPT) state_nxt = HALT ? S_HALTED : S_FETCH;
            default:          state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q      <= '0;
            instr_q   <= '0;
            instr_cnt <= '0;
        end else begin
            if (start_ok) begin
                pc_q      <= START_ADDR;
                instr_cnt <= '0;
            end else if (retire) begin
                if (instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'd1;
                // A halt leaves the PC pointing at the halting instruction.
                if (!HALT) pc_q <= take ? BRANCH_TARGET : pc_q + PC_W'(1);
            end
            if (state == S_FETCH && IMEM_VALID) instr_q <= IMEM_RDATA;
        end
    end

`ifdef FETCH_BRANCH_STATS_EN
    logic [15:0] taken_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                taken_cnt <= '0;
        else if (start_ok)                        taken_cnt <= '0;
        else if (take && taken_cnt != 16'hFFFF)   taken_cnt <= taken_cnt + 16'd1;
    end

    assign TAKEN_COUNT = taken_cnt;
`else
    assign TAKEN_COUNT = 16'h0000;
`endif

    assign IMEM_REQ    = (state == S_FETCH);
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[INSTR_W-1 -: OPC_W];
    assign INSTR_VALID = (state == S_ISSUE);
    assign RUNNING     = (state == S_FETCH) || (state == S_ISSUE);
    assign INSTR_COUNT = instr_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the bench plays instruction memory and the
// execute/control side. Inputs are driven and outputs sampled on the falling edge.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [7:0]  START_ADDR;
    logic        IMEM_REQ;
    logic [7:0]  IMEM_ADDR;
    logic [8:0]  IMEM_RDATA;
    logic        IMEM_VALID;
    logic [3:0]  OPCODE;
    logic [8:0]  INSTR;
    logic        INSTR_VALID;
    logic        ACCEPT;
    logic        BRANCH;
    logic        TAKEN;
    logic [7:0]  BRANCH_TARGET;
    logic        HALT;
    logic [7:0]  PC;
    logic        RUNNING;
    logic [15:0] INSTR_COUNT;
    logic [15:0] TAKEN_COUNT;

    int n_asrt = 0;
    int n_fail = 0;

`ifdef FETCH_BRANCH_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    instr_fetch_unit #(.PC_W(8), .INSTR_W(9), .OPC_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
        .IMEM_VALID(IMEM_VALID), .OPCODE(OPCODE), .INSTR(INSTR),
        .INSTR_VALID(INSTR_VALID), .ACCEPT(ACCEPT), .BRANCH(BRANCH), .TAKEN(TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .HALT(HALT), .PC(PC), .RUNNING(RUNNING),
        .INSTR_COUNT(INSTR_COUNT), .TAKEN_COUNT(TAKEN_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic start_at(input logic [7:0] addr);
        START_ADDR = addr;
        START = 1'b1;
        tick;
        START = 1'b0;
    endtask

    // Wait (bounded) for the request, check address, return word after lat idle cycles.
    task automatic do_fetch(input string tag, input logic [8:0] word, input int lat,
                            input logic [7:0] exp_addr);
        for (int i = 0; i < 20 && !IMEM_REQ; i++) tick;
        chk({tag, "_req"}, IMEM_REQ, 1);
        chk({tag, "_addr"}, IMEM_ADDR, exp_addr);
        repeat (lat) tick;
        chk({tag, "_req_hold"}, IMEM_REQ, 1);
        IMEM_VALID = 1'b1;
        IMEM_RDATA = word;
        tick;
        IMEM_VALID = 1'b0;
        IMEM_RDATA = 9'h000;
        chk({tag, "_ivalid"}, INSTR_VALID, 1);
        chk({tag, "_opcode"}, OPCODE, word[8:5]);
        chk({tag, "_instr"}, INSTR, word);
        chk({tag, "_noreq"}, IMEM_REQ, 0);
    endtask

    task automatic do_accept(input string tag, input logic br, input logic tk,
                             input logic [7:0] tgt, input logic hl);
        ACCEPT = 1'b1;
        BRANCH = br;
        TAKEN = tk;
        BRANCH_TARGET = tgt;
        HALT = hl;
        tick;
        ACCEPT = 1'b0;
        BRANCH = 1'b0;
        TAKEN = 1'b0;
        HALT = 1'b0;
        BRANCH_TARGET = 8'h00;
        chk({tag, "_ivalid_fall"}, INSTR_VALID, 0);
    endtask

    initial begin
        logic [8:0] held;
        RESET = 1'b1; START = 1'b0; START_ADDR = 8'h00; IMEM_RDATA = 9'h000;
        IMEM_VALID = 1'b0; ACCEPT = 1'b0; BRANCH = 1'b0; TAKEN = 1'b0;
        BRANCH_TARGET = 8'h00; HALT = 1'b0;
        repeat (2) tick;
        RESET = 1'b0;
        tick;

        chk("rst_req", IMEM_REQ, 0);
        chk("rst_pc", PC, 8'h00);
        chk("rst_instr", INSTR, 9'h000);
        chk("rst_opc", OPCODE, 4'h0);
        chk("rst_ivalid", INSTR_VALID, 0);
        chk("rst_running", RUNNING, 0);
        chk("rst_icnt", INSTR_COUNT, 16'h0);
        chk("rst_tcnt", TAKEN_COUNT, 16'h0);

        // Reset while a fetch is outstanding.
        start_at(8'h10);
        chk("mf_req", IMEM_REQ, 1);
        chk("mf_addr", IMEM_ADDR, 8'h10);
        repeat (3) tick;
        chk("mf_still_req", IMEM_REQ, 1);
        RESET = 1'b1;
        #1;
        chk("mf_async_req", IMEM_REQ, 0);
        chk("mf_async_pc", PC, 8'h00);
        chk("mf_async_running", RUNNING, 0);
        @(negedge CLK);
        RESET = 1'b0;
        IMEM_VALID = 1'b1;
        IMEM_RDATA = 9'h1FF;
        tick;
        IMEM_VALID = 1'b0;
        tick;
        chk("mf_late_ivalid", INSTR_VALID, 0);
        chk("mf_late_instr", INSTR, 9'h000);
        chk("mf_late_req", IMEM_REQ, 0);
        chk("mf_late_running", RUNNING, 0);

        // Sequential run with varying memory latency.
        start_at(8'h20);
        chk("seq_running", RUNNING, 1);
        do_fetch("seq0", {4'd2, 5'h0A}, 0, 8'h20);
        do_accept("seq0", 0, 0, 8'h00, 0);
        do_fetch("seq1", {4'd1, 5'h11}, 3, 8'h21);
        do_accept("seq1", 0, 0, 8'h00, 0);
        do_fetch("seq2", {4'd3, 5'h05}, 1, 8'h22);
        do_accept("seq2", 0, 0, 8'h00, 0);
        chk("seq_icnt", INSTR_COUNT, 16'd3);
        do_fetch("seq3", {4'hF, 5'h00}, 0, 8'h23);
        do_accept("seq3", 0, 0, 8'h00, 1);
        chk("seqh_pc", PC, 8'h23);
        chk("seqh_running", RUNNING, 0);
        chk("seqh_icnt", INSTR_COUNT, 16'd4);

        // Taken branch, then not-taken branch from the same address.
        start_at(8'h05);
        chk("br_icnt_clr", INSTR_COUNT, 16'd0);
        do_fetch("br0", {4'd6, 5'h01}, 2, 8'h05);
        do_accept("br0", 1, 1, 8'h40, 0);
        chk("br0_tcnt", TAKEN_COUNT, STATS);
        do_fetch("br1", {4'd6, 5'h02}, 0, 8'h40);
        do_accept("br1", 1, 1, 8'h05, 0);
        chk("br1_tcnt", TAKEN_COUNT, 2 * STATS);
        do_fetch("br2", {4'd6, 5'h01}, 1, 8'h05);
        do_accept("br2", 1, 0, 8'h40, 0);
        chk("br2_tcnt", TAKEN_COUNT, 2 * STATS);
        do_fetch("br3", {4'd3, 5'h03}, 0, 8'h06);
        do_accept("br3", 0, 0, 8'h00, 1);
        chk("br_icnt", INSTR_COUNT, 16'd4);

        // PC wrap, then halt beats a taken branch.
        start_at(8'hFF);
        chk("wr_tcnt_clr", TAKEN_COUNT, 16'd0);
        do_fetch("wr0", {4'd1, 5'h00}, 0, 8'hFF);
        do_accept("wr0", 0, 0, 8'h00, 0);
        do_fetch("wr1", {4'd6, 5'h00}, 0, 8'h00);
        do_accept("wr1", 1, 1, 8'h33, 0);
        do_fetch("hl0", {4'hF, 5'h1F}, 0, 8'h33);
        do_accept("hl0", 1, 1, 8'h77, 1);
        chk("hl_pc", PC, 8'h33);
        chk("hl_running", RUNNING, 0);
        chk("hl_icnt", INSTR_COUNT, 16'd3);
        chk("hl_tcnt", TAKEN_COUNT, STATS);
        for (int i = 0; i < 10; i++) begin
            chk("hl_noreq", IMEM_REQ, 0);
            tick;
        end
        chk("hl_pc_hold", PC, 8'h33);

        // Restart from HALTED.
        start_at(8'h50);
        chk("rs_icnt", INSTR_COUNT, 16'd0);
        chk("rs_tcnt", TAKEN_COUNT, 16'd0);
        do_fetch("rs0", {4'd9, 5'h15}, 1, 8'h50);

        // Stall in ISSUE with noise on every ignored input.
        held = {4'd9, 5'h15};
        for (int i = 0; i < 5; i++) begin
            HALT = i[0];
            BRANCH = ~i[0];
            TAKEN = 1'b1;
            BRANCH_TARGET = 8'hC0;
            START = (i == 2);
            START_ADDR = 8'hAA;
            IMEM_VALID = (i == 3);
            IMEM_RDATA = 9'h0F0;
            tick;
            chk("st_instr", INSTR, held);
            chk("st_opc", OPCODE, held[8:5]);
            chk("st_ivalid", INSTR_VALID, 1);
            chk("st_pc", PC, 8'h50);
            chk("st_icnt", INSTR_COUNT, 16'd0);
            chk("st_noreq", IMEM_REQ, 0);
        end
        HALT = 1'b0; BRANCH = 1'b0; TAKEN = 1'b0; START = 1'b0; IMEM_VALID = 1'b0;
        do_accept("st", 0, 0, 8'h00, 0);
        chk("st_icnt_after", INSTR_COUNT, 16'd1);
        chk("st_tcnt_after", TAKEN_COUNT, 16'd0);
        chk("st_next_req", IMEM_REQ, 1);
        chk("st_next_addr", IMEM_ADDR, 8'h51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
